exec_mem_pipe: RTL and testbench

//  Pipelined, parametrised successor to the single-cycle register/ALU/memory datapath.

---
 rtl/exec_pkg.sv | 75 +++++++
 rtl/exec_datamem.sv | 26 ++
 rtl/exec_mem_pipe.sv | 168 ++++++++++++++++
 tb/tb_exec_mem_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types, ALU encodings and the ALU evaluation function for the
// execute/memory pipeline.
package exec_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned SUM_W  = DATA_W + 1;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // data holds store data for stores, link address for link ops, else ALU result
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;
    logic              mem_rd;
    logic              mem_wr;
    logic              link;
  } ex_op_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
  } alu_out_t;

  // flags = {negative, zero, overflow, carry_out}; SUB carry is A + ~B + 1
  function automatic alu_out_t alu_eval(input logic [2:0]        op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] dif;
    logic             v;
    logic             c;
    alu_out_t         o;
    sum      = {1'b0, a} + {1'b0, b};
    dif      = {1'b0, a} + {1'b0, ~b} + SUM_W'(1);
    v        = 1'b0;
    c        = 1'b0;
    o.result = '0;
    case (op)
      ALU_PASS_B: o.result = b;
      ALU_ADD: begin
        o.result = sum[DATA_W-1:0];
        c        = sum[DATA_W];
        v        = (a[DATA_W-1] == b[DATA_W-1]) && (o.result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        o.result = dif[DATA_W-1:0];
        c        = dif[DATA_W];
        v        = (a[DATA_W-1] != b[DATA_W-1]) && (o.result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: o.result = a & b;
      ALU_OR:  o.result = a | b;
      ALU_XOR: o.result = a ^ b;
      default: o.result = '0;
    endcase
    o.flags = {o.result[DATA_W-1], (o.result == '0), v, c};
    return o;
  endfunction

endpackage

// File: rtl/exec_datamem.sv
// Word-addressed data memory: synchronous write, registered read.
module exec_datamem
  import exec_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
    rdata <= mem[ridx];
  end

endmodule

// File: rtl/exec_mem_pipe.sv
// EX -> MEM -> WB pipeline: ALU on issue, optional fixed-latency memory access,
// tagged result onto the CDB under valid/ready backpressure, flushable.
module exec_mem_pipe
  import exec_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_opA,
  input  logic [DATA_W-1:0] in_opB,
  input  logic [8:0]        in_dAddr9,
  input  logic [11:0]       in_imm12,
  input  logic [2:0]        in_ALUOp,
  input  logic              in_ALUSrc,
  input  logic              in_dOrImm,
  input  logic              in_memRead,
  input  logic              in_memWrite,
  input  logic              in_linkSel,
  input  logic [DATA_W-1:0] in_linkAddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [FLAG_W-1:0] out_flags
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  ex_op_t            ex_q;
  ex_op_t            ex_d;
  alu_out_t          alu_o;
  logic [DATA_W-1:0] b_sel;
  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [TAG_W-1:0]  m_tag;
  logic [FLAG_W-1:0] m_flags;
  logic [IDX_W-1:0]  m_idx;
  logic [DATA_W-1:0] m_data;
  logic              m_use_mem;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] m_result;
  logic [IDX_W-1:0]  ex_idx;
  logic [IDX_W-1:0]  ridx;
  logic              wb_free;
  logic              ex_adv;
  logic              accept;
  logic              ex_is_mem;
  logic              mem_we;

  // EX: operand B select and ALU, evaluated on the issue inputs
  always_comb begin
    b_sel = in_opB;
    if (in_ALUSrc) begin
      b_sel = in_dOrImm ? {{(DATA_W-12){in_imm12[11]}}, in_imm12}
                        : {{(DATA_W-9){in_dAddr9[8]}}, in_dAddr9};
    end
    alu_o       = alu_eval(in_ALUOp, in_opA, b_sel);
    ex_d.valid  = 1'b1;
    ex_d.tag    = in_tag;
    ex_d.alu    = alu_o.result;
    ex_d.data   = in_memWrite ? in_opB : (in_linkSel ? in_linkAddr : alu_o.result);
    ex_d.flags  = alu_o.flags;
    ex_d.mem_rd = in_memRead;
    ex_d.mem_wr = in_memWrite;
    ex_d.link   = in_linkSel;
  end

  // Handshake and memory port control
  always_comb begin
    wb_free   = !out_valid || out_ready;
    ex_adv    = ex_q.valid && (state == IDLE) && wb_free;
    in_ready  = !reset && !flush && (!ex_q.valid || ex_adv);
    accept    = in_valid && in_ready;
    ex_is_mem = ex_q.mem_rd || ex_q.mem_wr;
    mem_we    = ex_adv && ex_q.mem_wr && !reset && !flush;
    ex_idx    = IDX_W'(ex_q.alu >> 3);
    ridx      = (state == IDLE) ? ex_idx : m_idx;
    m_result  = m_use_mem ? rdata : m_data;
  end

  exec_datamem #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_datamem (
    .clk  (clk),
    .we   (mem_we),
    .widx (ex_idx),
    .wdata(ex_q.data),
    .ridx (ridx),
    .rdata(rdata)
  );

  // EXr, MEM FSM and WBr; only one memory op is ever in flight
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_q.valid <= 1'b0;
      out_valid  <= 1'b0;
      out_tag    <= '0;
      out_data   <= '0;
      out_flags  <= '0;
      state      <= IDLE;
      cnt        <= '0;
    end else begin
      if (accept) begin
        ex_q <= ex_d;
      end else if (ex_adv) begin
        ex_q.valid <= 1'b0;
      end

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ex_adv) begin
            if (ex_is_mem) begin
              state     <= WAIT;
              cnt       <= CNT_W'(MEM_LAT - 1);
              m_tag     <= ex_q.tag;
              m_flags   <= ex_q.flags;
              m_idx     <= ex_idx;
              m_data    <= ex_q.mem_wr ? '0 : ex_q.data;
              m_use_mem <= ex_q.mem_rd && !ex_q.mem_wr && !ex_q.link;
            end else begin
              out_valid <= 1'b1;
              out_tag   <= ex_q.tag;
              out_data  <= ex_q.data;
              out_flags <= ex_q.flags;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (wb_free) begin
            out_valid <= 1'b1;
            out_tag   <= m_tag;
            out_data  <= m_result;
            out_flags <= m_flags;
            state     <= IDLE;
          end else begin
            m_data    <= m_result;
            m_use_mem <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (wb_free) begin
            out_valid <= 1'b1;
            out_tag   <= m_tag;
            out_data  <= m_data;
            out_flags <= m_flags;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mem_pipe.sv
// Scoreboard bench for exec_mem_pipe: expected CDB results are queued on issue
// and checked (tag, data, flags, latency) when the DUT transfers them.
module tb_exec_mem_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [5:0]  in_tag;
  logic [63:0] in_opA, in_opB, in_linkAddr;
  logic [8:0]  in_dAddr9;
  logic [11:0] in_imm12;
  logic [2:0]  in_ALUOp;
  logic        in_ALUSrc, in_dOrImm, in_memRead, in_memWrite, in_linkSel;
  logic        out_valid, out_ready;
  logic [5:0]  out_tag;
  logic [63:0] out_data;
  logic [3:0]  out_flags;

  localparam logic [2:0] OP_PASS = 3'b000, OP_ADD = 3'b010, OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100, OP_OR = 3'b101, OP_XOR = 3'b110;

  typedef struct {
    logic [5:0]  tag;
    logic [63:0] data;
    logic [3:0]  flags;
    logic [3:0]  fmask;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   seen = 1'b0;
  int   seen_cyc = 0;

  exec_mem_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_opA(in_opA), .in_opB(in_opB), .in_dAddr9(in_dAddr9), .in_imm12(in_imm12),
    .in_ALUOp(in_ALUOp), .in_ALUSrc(in_ALUSrc), .in_dOrImm(in_dOrImm),
    .in_memRead(in_memRead), .in_memWrite(in_memWrite),
    .in_linkSel(in_linkSel), .in_linkAddr(in_linkAddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard: compare every CDB transfer against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1 && !seen) begin
      seen     = 1'b1;
      seen_cyc = cyc;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_result: got tag=%0d data=%h, required no result", out_tag, out_data);
      end else begin
        e = sb.pop_front();
        vectors++;
        if (out_tag !== e.tag) begin
          miscompares++;
          $display("FAIL result_tag: got %0d, required %0d", out_tag, e.tag);
        end
        vectors++;
        if (out_data !== e.data) begin
          miscompares++;
          $display("FAIL result_data tag=%0d: got %h, required %h", e.tag, out_data, e.data);
        end
        vectors++;
        if ((out_flags & e.fmask) !== (e.flags & e.fmask)) begin
          miscompares++;
          $display("FAIL result_flags tag=%0d: got %b, required %b (mask %b)", e.tag, out_flags, e.flags, e.fmask);
        end
        if (e.cyc >= 0) begin
          vectors++;
          if (seen_cyc != e.cyc) begin
            miscompares++;
            $display("FAIL result_latency tag=%0d: out_valid at cycle %0d, required %0d", e.tag, seen_cyc, e.cyc);
          end
        end
      end
      seen = 1'b0;
    end
  end

  function automatic logic [67:0] ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic        v, c;
    v = 1'b0; c = 1'b0; r = '0;
    case (op)
      OP_PASS: r = b;
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {r[63], (r == 64'd0), v, c, r};
  endfunction

  // Drive one op until accepted; starts and ends just after a rising edge
  task automatic issue(input logic [5:0] tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic src, input logic dimm,
                       input logic [8:0] d9, input logic [11:0] imm, input logic rd,
                       input logic wr, input logic lnk, input logic [63:0] la,
                       input logic exp_on, input logic [63:0] exp_data,
                       input logic [3:0] exp_flags, input logic [3:0] fmask,
                       input int lat, output int acc);
    int   waited;
    exp_t e;
    waited = 0;
    in_valid = 1'b1; in_tag = tag; in_ALUOp = op; in_opA = a; in_opB = b;
    in_ALUSrc = src; in_dOrImm = dimm; in_dAddr9 = d9; in_imm12 = imm;
    in_memRead = rd; in_memWrite = wr; in_linkSel = lnk; in_linkAddr = la;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    acc = cyc;
    if (in_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout tag=%0d: in_ready=%b, required 1 within 50 cycles", tag, in_ready);
    end else if (exp_on) begin
      e.tag = tag; e.data = exp_data; e.flags = exp_flags; e.fmask = fmask;
      e.cyc = (lat < 0) ? -1 : cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_tag = '0; in_opA = '0; in_opB = '0; in_dAddr9 = '0; in_imm12 = '0; in_ALUOp = '0;
    in_ALUSrc = 1'b0; in_dOrImm = 1'b0; in_memRead = 1'b0; in_memWrite = 1'b0;
    in_linkSel = 1'b0; in_linkAddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_low: got %b, required 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    vectors++;
    if (out_tag !== 6'd0) begin miscompares++; $display("FAIL reset_out_tag: got %0d, required 0", out_tag); end
    vectors++;
    if (out_data !== 64'd0) begin miscompares++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    vectors++;
    if (out_flags !== 4'd0) begin miscompares++; $display("FAIL reset_out_flags: got %b, required 0000", out_flags); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_high: got %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int acc;
    issue(6'd1, OP_ADD, 64'd5, 64'd7, 1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b0, 64'd0,
          1'b1, 64'd12, 4'b0000, 4'hF, 2, acc);
    drain();
    issue(6'd7, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b0, 64'd0,
          1'b1, 64'h8000_0000_0000_0000, 4'b1010, 4'hF, 2, acc);
    issue(6'd8, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b0, 64'd0,
          1'b1, 64'd0, 4'b0101, 4'hF, 2, acc);
    drain();
  endtask

  task automatic test_sub_imm();
    int acc;
    issue(6'd9, OP_SUB, 64'd3, 64'd99, 1'b1, 1'b1, 9'd0, 12'd3, 1'b0, 1'b0, 1'b0, 64'd0,
          1'b1, 64'd0, 4'b0100, 4'b0100, 2, acc);
    drain();
  endtask

  task automatic test_link();
    int acc;
    issue(6'd11, OP_ADD, 64'd1, 64'd1, 1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b1, 64'h4000,
          1'b1, 64'h4000, 4'b0000, 4'hF, 2, acc);
    drain();
  endtask

  task automatic test_back_to_back();
    int          acc[8];
    logic [2:0]  ops[5];
    logic [2:0]  op;
    logic [63:0] a, b;
    logic [67:0] r;
    ops = '{OP_PASS, OP_ADD, OP_AND, OP_OR, OP_XOR};
    for (int i = 0; i < 8; i++) begin
      op = ops[$urandom_range(0, 4)];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      r = ref_alu(op, a, b);
      issue(6'(40 + i), op, a, b, 1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b0, 64'd0,
            1'b1, r[63:0], r[67:64], 4'hF, 2, acc[i]);
    end
    for (int i = 1; i < 8; i++) begin
      vectors++;
      if (acc[i] != acc[0] + i) begin
        miscompares++;
        $display("FAIL throughput op%0d: accepted at cycle %0d, required %0d", i, acc[i], acc[0] + i);
      end
    end
    drain();
  endtask

  task automatic test_mem();
    int acc;
    issue(6'd2, OP_ADD, 64'h100, 64'hDEAD, 1'b1, 1'b0, 9'h1F8, 12'd0, 1'b0, 1'b1, 1'b0, 64'd0,
          1'b1, 64'd0, 4'b0001, 4'hF, 4, acc);
    drain();
    issue(6'd3, OP_ADD, 64'h100, 64'd0, 1'b1, 1'b0, 9'h1F8, 12'd0, 1'b1, 1'b0, 1'b0, 64'd0,
          1'b1, 64'hDEAD, 4'b0001, 4'hF, 4, acc);
    drain();
    issue(6'd4, OP_ADD, 64'h20FD, 64'd0, 1'b1, 1'b0, 9'd0, 12'd0, 1'b1, 1'b0, 1'b0, 64'd0,
          1'b1, 64'hDEAD, 4'b0000, 4'hF, 4, acc);
    drain();
    issue(6'd5, OP_ADD, 64'h200, 64'hBEEF, 1'b1, 1'b0, 9'd0, 12'd0, 1'b1, 1'b1, 1'b0, 64'd0,
          1'b1, 64'd0, 4'b0000, 4'hF, 4, acc);
    drain();
    issue(6'd6, OP_ADD, 64'h200, 64'd0, 1'b1, 1'b0, 9'd0, 12'd0, 1'b1, 1'b0, 1'b0, 64'd0,
          1'b1, 64'hBEEF, 4'b0000, 4'hF, 4, acc);
    drain();
  endtask

  task automatic test_backpressure();
    int acc0, acc1, acc2;
    out_ready = 1'b0;
    fork
      begin
        issue(6'd20, OP_ADD, 64'd100, 64'd0, 1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b0, 64'd0,
              1'b1, 64'd100, 4'b0000, 4'hF, -1, acc0);
        issue(6'd21, OP_ADD, 64'd101, 64'd1, 1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b0, 64'd0,
              1'b1, 64'd102, 4'b0000, 4'hF, -1, acc1);
        issue(6'd22, OP_ADD, 64'd102, 64'd2, 1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b0, 64'd0,
              1'b1, 64'd104, 4'b0000, 4'hF, -1, acc2);
      end
      begin
        repeat (5) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
        vectors++;
        if (out_data !== 64'd100) begin miscompares++; $display("FAIL bp_held_data: got %h, required %h", out_data, 64'd100); end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_duplicate: out_valid=%b, required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_load();
    int acc, hits;
    issue(6'd25, OP_ADD, 64'h100, 64'd0, 1'b1, 1'b0, 9'h1F8, 12'd0, 1'b1, 1'b0, 1'b0, 64'd0,
          1'b0, 64'd0, 4'b0000, 4'hF, -1, acc);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid === 1'b1) hits++;
    end
    vectors++;
    if (hits != 0) begin miscompares++; $display("FAIL flush_killed_load: out_valid seen %0d cycles, required 0", hits); end
    @(posedge clk); #1;
    issue(6'd30, OP_ADD, 64'd40, 64'd2, 1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b0, 64'd0,
          1'b1, 64'd42, 4'b0000, 4'hF, 2, acc);
    drain();
  endtask

  task automatic test_reset_mid_load();
    int acc, hits;
    issue(6'd31, OP_ADD, 64'h100, 64'd0, 1'b1, 1'b0, 9'h1F8, 12'd0, 1'b1, 1'b0, 1'b0, 64'd0,
          1'b0, 64'd0, 4'b0000, 4'hF, -1, acc);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out_valid: got %b, required 0", out_valid); end
    vectors++;
    if (out_tag !== 6'd0) begin miscompares++; $display("FAIL rst_mid_out_tag: got %0d, required 0", out_tag); end
    vectors++;
    if (out_data !== 64'd0) begin miscompares++; $display("FAIL rst_mid_out_data: got %h, required 0", out_data); end
    vectors++;
    if (out_flags !== 4'd0) begin miscompares++; $display("FAIL rst_mid_out_flags: got %b, required 0000", out_flags); end
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid === 1'b1) hits++;
    end
    vectors++;
    if (hits != 0) begin miscompares++; $display("FAIL rst_mid_killed_load: out_valid seen %0d cycles, required 0", hits); end
    @(posedge clk); #1;
    issue(6'd32, OP_ADD, 64'h100, 64'd0, 1'b1, 1'b0, 9'h1F8, 12'd0, 1'b1, 1'b0, 1'b0, 64'd0,
          1'b1, 64'hDEAD, 4'b0001, 4'hF, 4, acc);
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_imm();
    test_link();
    test_back_to_back();
    test_mem();
    test_backpressure();
    test_flush_load();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
